// File: rtl/match_scoreboard_if.sv
// match_scoreboard_if: match control inputs and scoreboard/status outputs
interface match_scoreboard_if #(
  parameter int NUM_TEAMS = 2,
  parameter int SCORE_DIGITS = 2,
  parameter int TIME_DIGITS = 3
);
  logic start;
  logic pause;
  logic overtime_en;
  logic [NUM_TEAMS-1:0] goal;
  logic [4*TIME_DIGITS-1:0] time_bcd;
  logic [NUM_TEAMS*4*SCORE_DIGITS-1:0] score_bcd;
  logic running;
  logic overtime;
  logic time_over;
  logic score_end;
  logic [NUM_TEAMS-1:0] winner;
  modport master (
    output start, pause, overtime_en, goal,
    input time_bcd, score_bcd, running, overtime, time_over, score_end, winner
  );
  modport slave (
    input start, pause, overtime_en, goal,
    output time_bcd, score_bcd, running, overtime, time_over, score_end, winner
  );
endinterface

// File: rtl/match_scoreboard.sv
// match_scoreboard: BCD countdown clock, BCD team scores, overtime and winner resolution
module match_scoreboard #(
  parameter int CLK_HZ = 25_000_000,
  parameter int NUM_TEAMS = 2,
  parameter int SCORE_DIGITS = 2,
  parameter int TIME_DIGITS = 3,
  parameter int MATCH_SECONDS = 120,
  parameter int WIN_SCORE = 5
) (
  input logic clk,
  input logic rst_n,
  match_scoreboard_if.slave bus
);
  localparam int SW = 4 * SCORE_DIGITS;
  localparam int TW = 4 * TIME_DIGITS;
  localparam int PW = CLK_HZ > 1 ? $clog2(CLK_HZ) : 1;
  localparam bit WIN_ON = WIN_SCORE > 0 && WIN_SCORE < 10 ** SCORE_DIGITS;
  function automatic logic [31:0] bcd32(input int v);
    int r;
    logic [31:0] b;
    r = v;
    b = '0;
    for (int d = 0; d < 8; d++) begin
      b[d*4+:4] = 4'(r % 10);
      r = r / 10;
    end
    return b;
  endfunction
  localparam logic [TW-1:0] T_LOAD = TW'(bcd32(MATCH_SECONDS));
  localparam logic [SW-1:0] W_BCD = SW'(bcd32(WIN_SCORE));
  localparam logic [SW-1:0] NINES = {SCORE_DIGITS{4'h9}};
  function automatic logic [SW-1:0] inc(input logic [SW-1:0] v);
    logic [SW-1:0] r;
    logic c;
    r = v;
    c = 1'b1;
    for (int d = 0; d < SCORE_DIGITS; d++) begin
      if (c) begin
        c = r[d*4+:4] == 4'h9;
        r[d*4+:4] = c ? 4'h0 : r[d*4+:4] + 4'h1;
      end
    end
    return v == NINES ? v : r;
  endfunction
  function automatic logic [TW-1:0] dec(input logic [TW-1:0] v);
    logic [TW-1:0] r;
    logic b;
    r = v;
    b = 1'b1;
    for (int d = 0; d < TIME_DIGITS; d++) begin
      if (b) begin
        b = r[d*4+:4] == 4'h0;
        r[d*4+:4] = b ? 4'h9 : r[d*4+:4] - 4'h1;
      end
    end
    return r;
  endfunction
  // one-hot of the team holding the maximum alone; zero when the maximum is shared
  function automatic logic [NUM_TEAMS-1:0] lead(input logic [NUM_TEAMS*SW-1:0] s);
    logic [SW-1:0] mx;
    logic [NUM_TEAMS-1:0] hit;
    mx = '0;
    for (int i = 0; i < NUM_TEAMS; i++) if (s[i*SW+:SW] > mx) mx = s[i*SW+:SW];
    for (int i = 0; i < NUM_TEAMS; i++) hit[i] = s[i*SW+:SW] == mx;
    return (hit & (hit - NUM_TEAMS'(1))) == '0 ? hit : '0;
  endfunction
  typedef enum logic [2:0] {IDLE, RUN, PAUSED, OVERTIME, DONE} state_t;
  state_t state, state_n, ret, ret_n;
  logic [PW-1:0] presc, presc_n;
  logic [TW-1:0] tmr, tmr_n;
  logic [NUM_TEAMS*SW-1:0] score, score_n, scored;
  logic tover, tover_n, send, send_n, hit_win, tick;
  logic [NUM_TEAMS-1:0] winner, winner_n, ldr;
  assign tick = presc == PW'(CLK_HZ - 1);
  assign ldr = lead(scored);
  always_comb begin
    scored = score;
    hit_win = 1'b0;
    for (int i = 0; i < NUM_TEAMS; i++) begin
      if (bus.goal[i]) scored[i*SW+:SW] = inc(score[i*SW+:SW]);
      if (WIN_ON && bus.goal[i] && scored[i*SW+:SW] >= W_BCD) hit_win = 1'b1;
    end
  end
  always_comb begin
    state_n = state;
    ret_n = ret;
    presc_n = presc;
    tmr_n = tmr;
    score_n = score;
    tover_n = tover;
    send_n = send;
    winner_n = '0;
    if (bus.start) begin
      state_n = RUN;
      presc_n = '0;
      tmr_n = T_LOAD;
      score_n = '0;
      tover_n = 1'b0;
      send_n = 1'b0;
    end else begin
      case (state)
        RUN, OVERTIME: begin
          if (bus.pause) begin
            state_n = PAUSED;
            ret_n = state;
          end else begin
            score_n = scored;
            if (state == RUN) begin
              presc_n = tick ? '0 : presc + PW'(1);
              if (tick) tmr_n = dec(tmr);
            end
            // a winning goal outranks the clock running out on the same edge
            if (hit_win || (state == OVERTIME && |bus.goal && ldr != '0)) begin
              state_n = DONE;
              send_n = 1'b1;
            end else if (state == RUN && tick && tmr == TW'(1)) begin
              state_n = (ldr == '0 && bus.overtime_en) ? OVERTIME : DONE;
              tover_n = !(ldr == '0 && bus.overtime_en);
            end
          end
        end
        PAUSED: state_n = bus.pause ? PAUSED : ret;
        DONE: winner_n = lead(score);
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ret <= IDLE;
      presc <= '0;
      tmr <= '0;
      score <= '0;
      tover <= 1'b0;
      send <= 1'b0;
      winner <= '0;
    end else begin
      state <= state_n;
      ret <= ret_n;
      presc <= presc_n;
      tmr <= tmr_n;
      score <= score_n;
      tover <= tover_n;
      send <= send_n;
      winner <= winner_n;
    end
  end
  assign bus.time_bcd = tmr;
  assign bus.score_bcd = score;
  assign bus.running = state == RUN || state == OVERTIME;
  assign bus.overtime = state == OVERTIME;
  assign bus.time_over = tover;
  assign bus.score_end = send;
  assign bus.winner = winner;
endmodule

// File: doc/match_scoreboard.md
# match_scoreboard

Parametrised match controller and scoreboard for the soccer game: BCD countdown clock, per-team BCD goal counters, goal-limit and golden-goal overtime endings, pause, and winner resolution. Sits beside the game FSM on the 25 MHz pixel clock. It consumes goal pulses from the collision logic and drives TimeBCD/ScoreBCD to the color mapper and end-of-match flags to the FSM. It supersedes the fixed two-team scoreboard and adds team count, digit widths, win limit and overtime.

## Interface
- CLK_HZ, 25_000_000, clock cycles per displayed second (benches use 10)
- NUM_TEAMS, 2, number of teams (2..4)
- SCORE_DIGITS, 2, BCD digits per team score
- TIME_DIGITS, 3, BCD digits of match clock
- MATCH_SECONDS, 120, match length loaded on Start; must fit TIME_DIGITS
- WIN_SCORE, 5, score that ends the match immediately; 0 disables
- Clk  in  1  system clock
- Reset_n  in  1  asynchronous, active-low reset
- Start  in  1  one-cycle pulse; (re)starts a match from any state
- Pause  in  1  level; freezes clock and ignores goals while high
- OvertimeEn  in  1  level, sampled at expiry; enables golden-goal overtime on a tie
- Goal  in  NUM_TEAMS  one-cycle pulse per team; bit i scores for team i
- TimeBCD  out  4*TIME_DIGITS  remaining seconds, BCD, digit 0 in LSBs
- ScoreBCD  out  NUM_TEAMS*4*SCORE_DIGITS  team i occupies slice i
- Running  out  1  high in RUN or OVERTIME
- Overtime  out  1  high in OVERTIME
- TimeOver  out  1  high in DONE when ended by clock expiry
- ScoreEnd  out  1  high in DONE when ended by WIN_SCORE or golden goal
- Winner  out  NUM_TEAMS  one-hot unique leader in DONE; all zero on tie or when not DONE

## Operation
- States: IDLE, RUN, PAUSED, OVERTIME, DONE. Reset → IDLE.
- All outputs are 0 in reset and in IDLE.
- Start, any state: load TimeBCD=MATCH_SECONDS, clear scores, prescaler and flags; go to RUN. Start wins over every simultaneous event.
- RUN: the prescaler counts 0..CLK_HZ-1. Count CLK_HZ-1 is a tick; the prescaler wraps and TimeBCD decrements with per-digit borrow (e.g. 100→099).
- Tick taking TimeBCD 1→0:
  - scores tied (max shared by ≥2 teams) and OvertimeEn=1 → OVERTIME.
  - otherwise → DONE with TimeOver=1.
- Goal[i] in RUN/OVERTIME: score i increments in BCD with carry and saturates at all-9s. Simultaneous goals all count in the same cycle. Goals in IDLE/PAUSED/DONE are dropped.
- WIN_SCORE≠0 and any updated score ≥ WIN_SCORE → DONE, ScoreEnd=1. This takes priority over expiry in the same cycle.
- Goal and final tick in the same cycle: the goal counts first, and the tie test uses the updated scores.
- OVERTIME: TimeBCD holds 000 and the prescaler is idle. Any goal cycle whose updated scores have a unique leader → DONE, ScoreEnd=1. If simultaneous goals keep a tie, stay in OVERTIME.
- Pause high in RUN/OVERTIME → PAUSED. The prescaler value and return state are saved. When Pause falls, return to the saved state and resume counting from the saved prescaler value.
- Pause is ignored in IDLE/DONE.
- DONE holds scores and TimeBCD until Start or reset.
- Score comparison is unsigned on the raw BCD vectors; BCD preserves ordering.

## Timing
- All state and outputs are registered. Events sampled at edge k are visible after edge k.
- Goal → ScoreBCD: 1 cycle. State flags update on the same edge.
- Winner: valid 1 cycle after DONE entry, registered from the final scores.
- Start → RUN and TimeBCD=MATCH_SECONDS: 1 cycle. First decrement occurs CLK_HZ cycles after RUN entry.
- Pause → PAUSED: 1 cycle. A tick due on the Pause-assert edge is suppressed.
- Reset_n low forces all registers to 0 / IDLE asynchronously. Release is synchronous to Clk.

## Test plan
- CLK_HZ=10, MATCH_SECONDS=3, OvertimeEn=0, Start:
  - TimeBCD 003 next cycle, 002 at +10 cycles, 000 at +30 cycles.
  - DONE with TimeOver=1, Winner=00 (0-0 tie).
- MATCH_SECONDS=100: first tick gives TimeBCD=099. SCORE_DIGITS=1, WIN_SCORE=0, 12 Goal[0] pulses: score saturates at 9.
- WIN_SCORE=3, three Goal[1] pulses:
  - ScoreBCD team1=03, DONE, ScoreEnd=1.
  - Winner=2'b10 one cycle later.
  - A further Goal[0] is ignored.
- Tie at expiry:
  - 1-1 with OvertimeEn=1 → Overtime=1, TimeBCD=000.
  - Goal=2'b11 → 2-2, still OVERTIME.
  - Goal[0] → DONE, ScoreEnd=1, Winner=01.
- Pause for 15 cycles at prescaler=4: TimeBCD and prescaler frozen and a Goal is dropped. After release, the next tick arrives 6 cycles later.
- Reset and restart:
  - Reset_n low mid-RUN: all outputs 0 immediately, without waiting for an edge.
  - Start issued in DONE or RUN, including together with a Goal: clock reloads, scores read 0, Goal is discarded.
